// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush controller.
// The datapath side (master) raises hazard requests; the controller (slave) returns enables, flushes and stats.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             load_use_stall_flag;
    logic             exe_redirect;
    logic             mem_busy;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_exe_flush;
    logic             exe_mem_we;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] memwait_cnt;
    logic             err_timeout;

    modport master (
        output load_use_stall_flag, exe_redirect, mem_busy,
        input  pc_we, if_id_we, if_id_flush, id_exe_flush, exe_mem_we,
        input  stall_cnt, flush_cnt, memwait_cnt, err_timeout
    );

    modport slave (
        input  load_use_stall_flag, exe_redirect, mem_busy,
        output pc_we, if_id_we, if_id_flush, id_exe_flush, exe_mem_we,
        output stall_cnt, flush_cnt, memwait_cnt, err_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline, with hazard statistics.
// state     | meaning
// ST_RUN    | normal issue; load-use bubbles and redirects handled in place
// ST_MEM_WAIT | data memory busy last cycle; pipeline frozen until it frees
// ST_FLUSH  | extra IF/ID flush cycles following a redirect
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [2:0]        FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        flush_left, flush_left_nxt;
    logic [WAIT_W-1:0] wait_ctr, wait_ctr_nxt;
    logic              stall_inc, flush_inc, memwait_inc, err_set;

    logic              pc_we, if_id_we, if_id_flush, id_exe_flush, exe_mem_we;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt, memwait_cnt;
    logic              err_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            flush_left <= '0;
            wait_ctr   <= '0;
        end else begin
            state      <= state_nxt;
            flush_left <= flush_left_nxt;
            wait_ctr   <= wait_ctr_nxt;
        end
    end

    // One priority chain serves every state: mem_busy, then redirect, then
    // the pending flush, then load-use. MEM_WAIT with memory free behaves as RUN.
    always_comb begin
        state_nxt      = state;
        flush_left_nxt = flush_left;
        wait_ctr_nxt   = wait_ctr;
        pc_we          = 1'b1;
        if_id_we       = 1'b1;
        exe_mem_we     = 1'b1;
        if_id_flush    = 1'b0;
        id_exe_flush   = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        memwait_inc    = rst_n && (state == ST_MEM_WAIT);
        err_set        = 1'b0;

        if (rst_n) begin
            if (hz.mem_busy) begin
                pc_we          = 1'b0;
                if_id_we       = 1'b0;
                exe_mem_we     = 1'b0;
                state_nxt      = ST_MEM_WAIT;
                flush_left_nxt = '0;
                if (state != ST_MEM_WAIT) begin
                    wait_ctr_nxt = WAIT_W'(1);
                end else if (wait_ctr != WAIT_MAX) begin
                    wait_ctr_nxt = wait_ctr + WAIT_W'(1);
                end
                err_set = (wait_ctr_nxt >= WAIT_MAX);
            end else if (hz.exe_redirect) begin
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
                flush_inc    = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt      = ST_FLUSH;
                    flush_left_nxt = FLUSH_LOAD;
                end else begin
                    state_nxt = ST_RUN;
                end
            end else if (state == ST_FLUSH) begin
                if_id_flush    = 1'b1;
                flush_left_nxt = flush_left - 3'd1;
                state_nxt      = (flush_left <= 3'd1) ? ST_RUN : ST_FLUSH;
            end else if (hz.load_use_stall_flag) begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_exe_flush = 1'b1;
                stall_inc    = 1'b1;
                state_nxt    = ST_RUN;
            end else begin
                state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (memwait_inc && (memwait_cnt != '1)) begin
                memwait_cnt <= memwait_cnt + CNT_W'(1);
            end
            if (err_set) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign hz.pc_we        = pc_we;
    assign hz.if_id_we     = if_id_we;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_exe_flush = id_exe_flush;
    assign hz.exe_mem_we   = exe_mem_we;
    assign hz.stall_cnt    = stall_cnt;
    assign hz.flush_cnt    = flush_cnt;
    assign hz.memwait_cnt  = memwait_cnt;
    assign hz.err_timeout  = err_timeout;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle comparison against a behavioural
// model plus hand-computed literal expectations at key points.
module tb_pipeline_hazard_ctrl;
    localparam int FC    = 2;
    localparam int MT    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n;
    logic chk_en = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (MT),
        .CNT_W       (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Model state: what the pipeline has seen so far, in plain integers.
    int m_stall, m_flush, m_memwait, m_run, m_flush_left;
    bit m_err, m_busy_prev;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stall = 0; m_flush = 0; m_memwait = 0; m_run = 0;
            m_flush_left = 0; m_err = 0; m_busy_prev = 0;
        end else begin
            if (m_busy_prev) m_memwait = sat(m_memwait + 1);
            if (hz.mem_busy) begin
                m_run = m_run + 1;
                if (m_run >= MT) m_err = 1;
                m_flush_left = 0;
                m_busy_prev = 1;
            end else begin
                m_run = 0;
                m_busy_prev = 0;
                if (hz.exe_redirect) begin
                    m_flush = sat(m_flush + 1);
                    m_flush_left = FC - 1;
                end else if (m_flush_left > 0) begin
                    m_flush_left = m_flush_left - 1;
                end else if (hz.load_use_stall_flag) begin
                    m_stall = sat(m_stall + 1);
                end
            end
        end
    end

    // {pc_we, if_id_we, if_id_flush, id_exe_flush, exe_mem_we}
    function automatic logic [4:0] exp_ctl();
        if (!rst_n)               return 5'b11001;
        if (hz.mem_busy)          return 5'b00000;
        if (hz.exe_redirect)      return 5'b11111;
        if (m_flush_left > 0)     return 5'b11101;
        if (hz.load_use_stall_flag) return 5'b00011;
        return 5'b11001;
    endfunction

    function automatic logic [4:0] act_ctl();
        return {hz.pc_we, hz.if_id_we, hz.if_id_flush, hz.id_exe_flush, hz.exe_mem_we};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctl", 32'(act_ctl()), 32'(exp_ctl()));
            chk("stall_cnt", 32'(hz.stall_cnt), 32'(m_stall));
            chk("flush_cnt", 32'(hz.flush_cnt), 32'(m_flush));
            chk("memwait_cnt", 32'(hz.memwait_cnt), 32'(m_memwait));
            chk("err_timeout", 32'(hz.err_timeout), 32'(m_err));
        end
    end

    task automatic step(input logic lu, input logic rd, input logic mb);
        hz.load_use_stall_flag = lu;
        hz.exe_redirect        = rd;
        hz.mem_busy            = mb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        hz.load_use_stall_flag = 1'b0;
        hz.exe_redirect        = 1'b1;
        hz.mem_busy            = 1'b1;
        #2;
        // Reset, no clock: enables high and no flush even with requests pending
        chk("rst_ctl", 32'(act_ctl()), 32'h19);
        chk("rst_stall", 32'(hz.stall_cnt), 0);
        chk("rst_flush", 32'(hz.flush_cnt), 0);
        chk("rst_memwait", 32'(hz.memwait_cnt), 0);
        chk("rst_err", 32'(hz.err_timeout), 0);
        step(0, 0, 0);
        clk_en = 1'b1;
        #2 rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // Load-use bubble
        step(1, 0, 0);
        chk("lu_ctl", 32'(act_ctl()), 32'h03);
        tick();
        step(0, 0, 0);
        chk("lu_stall_cnt", 32'(hz.stall_cnt), 1);
        chk("lu_done_ctl", 32'(act_ctl()), 32'h19);
        tick();

        // Redirect with two flush cycles
        step(0, 1, 0);
        chk("rd_c0_ctl", 32'(act_ctl()), 32'h1f);
        tick();
        step(0, 0, 0);
        chk("rd_c1_ctl", 32'(act_ctl()), 32'h1d);
        chk("rd_flush_cnt", 32'(hz.flush_cnt), 1);
        tick();
        step(0, 0, 0);
        chk("rd_c2_ctl", 32'(act_ctl()), 32'h19);
        tick();

        // mem_busy dominates redirect and load-use for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1);
            chk("busy_ctl", 32'(act_ctl()), 32'h00);
            tick();
        end
        step(0, 1, 0);
        chk("busy_exit_ctl", 32'(act_ctl()), 32'h1f);
        tick();
        chk("busy_memwait", 32'(hz.memwait_cnt), 3);
        chk("busy_flush_cnt", 32'(hz.flush_cnt), 2);
        step(0, 0, 0);
        chk("busy_post_flush", 32'(act_ctl()), 32'h1d);
        tick();
        step(0, 0, 0);
        tick();
        chk("no_err_yet", 32'(hz.err_timeout), 0);

        // Timeout: registered error appears after the 4th consecutive busy cycle
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1);
            chk("to_err", 32'(hz.err_timeout), (i >= 4) ? 1 : 0);
            tick();
        end
        step(0, 0, 0);
        tick();
        step(0, 0, 0);
        chk("to_err_sticky", 32'(hz.err_timeout), 1);
        chk("to_memwait", 32'(hz.memwait_cnt), 9);
        tick();

        // Redirect inside FLUSH, then mem_busy drops the remaining flush
        step(0, 1, 0);
        tick();
        step(0, 1, 0);
        chk("rd_in_flush_ctl", 32'(act_ctl()), 32'h1f);
        tick();
        step(0, 0, 1);
        chk("busy_in_flush_ctl", 32'(act_ctl()), 32'h00);
        tick();
        step(1, 0, 0);
        chk("lu_at_wait_exit", 32'(act_ctl()), 32'h03);
        tick();
        step(0, 0, 0);
        chk("flush_dropped", 32'(act_ctl()), 32'h19);
        chk("flush_cnt_4", 32'(hz.flush_cnt), 4);
        chk("stall_cnt_2", 32'(hz.stall_cnt), 2);
        tick();

        // Counter saturation
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0);
            tick();
        end
        step(0, 0, 0);
        chk("stall_sat", 32'(hz.stall_cnt), CMAX);
        tick();

        // Reset mid-FLUSH
        step(0, 1, 0);
        tick();
        step(0, 0, 0);
        chk("pre_rst_flush", 32'(act_ctl()), 32'h1d);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'(act_ctl()), 32'h19);
        chk("mid_rst_stall", 32'(hz.stall_cnt), 0);
        chk("mid_rst_flush", 32'(hz.flush_cnt), 0);
        chk("mid_rst_err", 32'(hz.err_timeout), 0);
        tick();
        rst_n = 1'b1;
        step(0, 0, 0);
        chk("post_rst_run", 32'(act_ctl()), 32'h19);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
